// File: rtl/msg_scroller_pkg.sv
// Shared types and constants for the message scroller: FSM states, the
// blank character code, default sizing and a width helper.
package scroll_pkg;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef logic [1:0] char_t;

  localparam char_t       BLANK            = 2'b11;
  localparam int unsigned TICK_DIV_DEFAULT = 50000000;
  localparam int unsigned MSG_LEN_DEFAULT  = 8;
  localparam int          NUM_CHARS        = 6;

  // Ceiling log2, never less than 1 so every derived vector has a bit.
  function automatic int unsigned clog2_w(input int unsigned n);
    int unsigned w;
    int unsigned v;
    w = 0;
    v = n - 1;
    while (v != 0) begin
      w = w + 1;
      v = v >> 1;
    end
    if (w == 0) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/msg_scroller_if.sv
// Character write channel: one 2-bit code per accepted valid/ready beat.
interface msg_scroller_if;
  import scroll_pkg::*;

  logic  wr_valid;
  char_t wr_data;
  logic  wr_ready;

  modport master (
    output wr_valid,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    output wr_ready
  );

endinterface

// File: rtl/msg_scroller_prescaler.sv
// Scroll-step prescaler: counts 0..TICK_DIV-1 while count_en is high, holds
// while it is low, and is forced to 0 by restart. tick marks the wrap cycle
// and is suppressed when restart is asserted in the same cycle.
module tick_prescaler
  import scroll_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic aclr,
  input  logic count_en,
  input  logic restart,
  output logic tick
);

  localparam int unsigned     CNT_W = clog2_w(TICK_DIV);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             at_term;

  assign at_term = (cnt_q == TERM);
  assign tick    = count_en & ~restart & at_term;

  // Prescale counter with hold on count_en low and synchronous restart.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      cnt_q <= '0;
    end else if (restart) begin
      cnt_q <= '0;
    end else if (count_en) begin
      cnt_q <= at_term ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/msg_scroller.sv
// Message scroller: loads MSG_LEN 2-bit character codes through the write
// channel, then rotates a 6-character window over them once per prescaler
// tick in the direction selected by dir.
//
// state | meaning
// ------+-----------------------------------------------------------
// LOAD  | accepting characters; window shows what is stored so far
// RUN   | message frozen; window offset steps on each enabled tick
module msg_scroller
  import scroll_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT,
  parameter int unsigned MSG_LEN  = MSG_LEN_DEFAULT
) (
  input  logic           clk,
  input  logic           aclr,
  input  logic           enable,
  input  logic           dir,
  input  logic           clear,
  msg_scroller_if.slave  wr,
  output char_t          char0,
  output char_t          char1,
  output char_t          char2,
  output char_t          char3,
  output char_t          char4,
  output char_t          char5,
  output logic           loading,
  output logic           tick
);

  localparam int unsigned      PTR_W = clog2_w(MSG_LEN);
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(MSG_LEN - 1);

  state_t           state_q;
  state_t           state_d;
  char_t            msg_q [MSG_LEN];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] offset_q;
  logic             in_load;
  logic             wr_fire;
  logic             run_start;
  logic             count_en;
  logic             restart;
  char_t            disp [NUM_CHARS];

  // Window index (base + step) mod MSG_LEN; step is always below MSG_LEN.
  function automatic logic [PTR_W-1:0] rot_idx(input logic [PTR_W-1:0] base,
                                               input int step);
    logic [PTR_W:0] sum;
    sum = {1'b0, base} + (PTR_W+1)'(step);
    if (sum >= (PTR_W+1)'(MSG_LEN)) sum = sum - (PTR_W+1)'(MSG_LEN);
    return sum[PTR_W-1:0];
  endfunction

  assign in_load     = (state_q == ST_LOAD);
  assign wr.wr_ready = in_load;
  assign loading     = in_load;

  // clear drops any coincident write.
  assign wr_fire   = wr.wr_valid & in_load & ~clear;
  assign run_start = wr_fire & (wr_ptr_q == LAST);

  assign count_en = (state_q == ST_RUN) & enable;
  assign restart  = clear | (state_q != ST_RUN);

  // Next-state logic: clear always returns to LOAD, last write enters RUN.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_LOAD: if (run_start) state_d = ST_RUN;
        ST_RUN:  state_d = ST_RUN;
        default: state_d = ST_LOAD;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) state_q <= ST_LOAD;
    else       state_q <= state_d;
  end

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk      (clk),
    .aclr     (aclr),
    .count_en (count_en),
    .restart  (restart),
    .tick     (tick)
  );

  // Message store: blanked on reset/clear, written only in LOAD.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      for (int i = 0; i < int'(MSG_LEN); i++) msg_q[i] <= BLANK;
    end else if (clear) begin
      for (int i = 0; i < int'(MSG_LEN); i++) msg_q[i] <= BLANK;
    end else if (wr_fire) begin
      msg_q[wr_ptr_q] <= wr.wr_data;
    end
  end

  // Write pointer: advances per accepted write, wraps after the last entry.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      wr_ptr_q <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
    end else if (wr_fire) begin
      wr_ptr_q <= (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    end
  end

  // Window offset: zeroed on entry to RUN, stepped by dir on each tick.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      offset_q <= '0;
    end else if (clear || run_start) begin
      offset_q <= '0;
    end else if (tick) begin
      if (dir) offset_q <= (offset_q == '0)  ? LAST : offset_q - PTR_W'(1);
      else     offset_q <= (offset_q == LAST) ? '0   : offset_q + PTR_W'(1);
    end
  end

  // Display window: six consecutive entries starting at the offset.
  always_comb begin
    for (int i = 0; i < NUM_CHARS; i++) disp[i] = msg_q[rot_idx(offset_q, i)];
  end

  assign char0 = disp[0];
  assign char1 = disp[1];
  assign char2 = disp[2];
  assign char3 = disp[3];
  assign char4 = disp[4];
  assign char5 = disp[5];

endmodule

// File: tb/tb_msg_scroller.sv
// Bench for msg_scroller with TICK_DIV=4, MSG_LEN=8: a vector table for
// reset/load/freeze, then directed sequences for scrolling, enable hold,
// clear priority and asynchronous reset.
module tb_msg_scroller;
  import scroll_pkg::*;

  localparam int TD = 4;
  localparam int ML = 8;

  logic  clk = 1'b0;
  logic  aclr = 1'b0;
  logic  enable = 1'b0;
  logic  dir = 1'b0;
  logic  clear = 1'b0;
  char_t char0, char1, char2, char3, char4, char5;
  logic  loading;
  logic  tick;
  logic [11:0] chars;

  msg_scroller_if wif ();

  always #5 clk = ~clk;

  msg_scroller #(
    .TICK_DIV (TD),
    .MSG_LEN  (ML)
  ) dut (
    .clk     (clk),
    .aclr    (aclr),
    .enable  (enable),
    .dir     (dir),
    .clear   (clear),
    .wr      (wif),
    .char0   (char0),
    .char1   (char1),
    .char2   (char2),
    .char3   (char3),
    .char4   (char4),
    .char5   (char5),
    .loading (loading),
    .tick    (tick)
  );

  assign chars = {char0, char1, char2, char3, char4, char5};

  int n_checks = 0;
  int n_fail   = 0;

  // reference model
  logic  m_run;
  char_t m_msg [ML];
  int    m_ptr;
  int    m_off;
  int    m_pre;

  typedef struct {
    logic        wv;
    logic [1:0]  wd;
    logic        en;
    logic        exp_rdy;
    logic        exp_tick;
    logic [11:0] exp_chars;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] model_chars();
    logic [11:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) r[11-2*i -: 2] = m_msg[(m_off + i) % ML];
    return r;
  endfunction

  task automatic model_reset();
    m_run = 1'b0;
    for (int i = 0; i < ML; i++) m_msg[i] = 2'b11;
    m_ptr = 0;
    m_off = 0;
    m_pre = 0;
  endtask

  task automatic drive(input logic en, input logic dr, input logic clr,
                       input logic wv, input logic [1:0] wd);
    @(negedge clk);
    enable       = en;
    dir          = dr;
    clear        = clr;
    wif.wr_valid = wv;
    wif.wr_data  = wd;
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_rdy"},   wif.wr_ready, !m_run);
    chk({tag, "_load"},  loading, !m_run);
    chk({tag, "_tick"},  tick, m_run && enable && !clear && (m_pre == TD - 1));
    chk({tag, "_chars"}, chars, model_chars());
  endtask

  task automatic advance();
    @(posedge clk);
    if (clear) begin
      model_reset();
    end else if (!m_run) begin
      if (wif.wr_valid) begin
        m_msg[m_ptr] = wif.wr_data;
        if (m_ptr == ML - 1) begin
          m_ptr = 0;
          m_off = 0;
          m_run = 1'b1;
        end else begin
          m_ptr++;
        end
      end
    end else if (enable) begin
      if (m_pre == TD - 1) begin
        m_pre = 0;
        m_off = dir ? (m_off + ML - 1) % ML : (m_off + 1) % ML;
      end else begin
        m_pre++;
      end
    end
  endtask

  task automatic cyc(input logic en, input logic dr, input logic clr,
                     input logic wv, input logic [1:0] wd, input string tag);
    drive(en, dr, clr, wv, wd);
    check_model(tag);
    advance();
  endtask

  initial begin
    int acc;
    logic [1:0] dirs [4];

    // wv, wd, en, exp_rdy, exp_tick, exp_chars (char0..char5)
    vt[0]  = '{1'b0, 2'b00, 1'b1, 1'b1, 1'b0, {2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11}};
    vt[1]  = '{1'b0, 2'b00, 1'b1, 1'b1, 1'b0, {2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11}};
    vt[2]  = '{1'b1, 2'b00, 1'b1, 1'b1, 1'b0, {2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11}};
    vt[3]  = '{1'b1, 2'b01, 1'b1, 1'b1, 1'b0, {2'b00, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11}};
    vt[4]  = '{1'b1, 2'b10, 1'b1, 1'b1, 1'b0, {2'b00, 2'b01, 2'b11, 2'b11, 2'b11, 2'b11}};
    vt[5]  = '{1'b1, 2'b11, 1'b1, 1'b1, 1'b0, {2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b11}};
    vt[6]  = '{1'b1, 2'b00, 1'b1, 1'b1, 1'b0, {2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b11}};
    vt[7]  = '{1'b1, 2'b01, 1'b1, 1'b1, 1'b0, {2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b11}};
    vt[8]  = '{1'b1, 2'b10, 1'b1, 1'b1, 1'b0, {2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01}};
    vt[9]  = '{1'b1, 2'b00, 1'b1, 1'b1, 1'b0, {2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01}};
    vt[10] = '{1'b1, 2'b11, 1'b0, 1'b0, 1'b0, {2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01}};
    vt[11] = '{1'b1, 2'b11, 1'b0, 1'b0, 1'b0, {2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01}};

    wif.wr_valid = 1'b0;
    wif.wr_data  = 2'b00;
    model_reset();

    // reset
    repeat (2) @(negedge clk);
    #1;
    chk("rst_chars", chars, 12'hFFF);
    chk("rst_rdy", wif.wr_ready, 1'b1);
    chk("rst_load", loading, 1'b1);
    chk("rst_tick", tick, 1'b0);
    @(negedge clk);
    aclr = 1'b1;

    // load table, then frozen in RUN
    acc = 0;
    for (int k = 0; k < 12; k++) begin
      drive(vt[k].en, 1'b0, 1'b0, vt[k].wv, vt[k].wd);
      if (wif.wr_valid && wif.wr_ready) acc++;
      chk($sformatf("tbl%0d_rdy", k), wif.wr_ready, vt[k].exp_rdy);
      chk($sformatf("tbl%0d_load", k), loading, vt[k].exp_rdy);
      chk($sformatf("tbl%0d_tick", k), tick, vt[k].exp_tick);
      chk($sformatf("tbl%0d_chars", k), chars, vt[k].exp_chars);
      advance();
    end
    chk("accepts", acc, 8);

    // scroll left: tick every 4th cycle, full rotation returns home
    for (int t = 1; t <= 8; t++) begin
      for (int c = 0; c < 4; c++) begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        chk("left_tick", tick, c == 3);
        check_model("left");
        advance();
      end
      #1;
      if (t == 1) chk("left_t1_chars", chars, {2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10});
      if (t == 8) chk("left_t8_chars", chars, {2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01});
    end

    // scroll right from offset 0; dir wiggles between ticks
    dirs = '{2'd0, 2'd1, 2'd0, 2'd1};
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, dirs[c][0], 1'b0, 1'b0, 2'b00);
      chk("right_tick", tick, c == 3);
      check_model("right");
      advance();
    end
    #1;
    chk("right_chars", chars, {2'b00, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00});

    // enable hold at prescaler 2
    for (int c = 0; c < 2; c++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, "pre");
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
      chk("hold_tick", tick, 1'b0);
      check_model("hold");
      advance();
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    chk("reen_first_tick", tick, 1'b0);
    advance();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    chk("reen_second_tick", tick, 1'b1);
    advance();
    #1;
    chk("reen_chars", chars, {2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01});

    // clear coincident with tick and write
    for (int c = 0; c < 3; c++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, "preclr");
    drive(1'b1, 1'b0, 1'b1, 1'b1, 2'b10);
    chk("clr_tick", tick, 1'b0);
    advance();
    #1;
    chk("clr_load", loading, 1'b1);
    chk("clr_rdy", wif.wr_ready, 1'b1);
    chk("clr_chars", chars, 12'hFFF);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'b10, "post_clr");
    #1;
    chk("clr_off0", chars, {2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11});

    // clear beats a write in LOAD
    drive(1'b0, 1'b0, 1'b1, 1'b1, 2'b00);
    advance();
    #1;
    chk("clr_vs_wr", chars, 12'hFFF);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'b10, "reload");
    #1;
    chk("reload_ptr0", chars, {2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11});
    for (int c = 0; c < 7; c++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, "reload");
    #1;
    chk("reload_run", loading, 1'b0);
    for (int c = 0; c < 4; c++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, "run2");
    #1;
    chk("pre_aclr_chars", chars, 12'h555);

    // asynchronous reset mid-scroll
    @(negedge clk);
    #2;
    aclr = 1'b0;
    #1;
    chk("aclr_chars", chars, 12'hFFF);
    chk("aclr_load", loading, 1'b1);
    chk("aclr_rdy", wif.wr_ready, 1'b1);
    chk("aclr_tick", tick, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    chk("aclr_tick_hold", tick, 1'b0);
    @(negedge clk);
    aclr = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, "post_aclr");
    #1;
    chk("aclr_ptr0", chars, {2'b01, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/msg_scroller.md
MSG_SCROLLER -- requirements
Module: msg_scroller

Interface
REQ-001 Parameter TICK_DIV, default 50000000, clk cycles per scroll step (>=2).
REQ-002 Parameter MSG_LEN, default 8, message length in 2-bit character codes (>=6).
REQ-003 clk  in  1  system clock, all state on rising edge.
REQ-004 aclr  in  1  asynchronous active-low reset.
REQ-005 enable  in  1  scrolling permitted while high.
REQ-006 dir  in  1  0 = scroll left (offset+1), 1 = scroll right (offset-1).
REQ-007 clear  in  1  synchronous request to blank the message and return to loading.
REQ-008 wr_valid  in  1  write request, one character.
REQ-009 wr_data  in  2  character code to write.
REQ-010 wr_ready  out  1  high while character accepted; write occurs when wr_valid & wr_ready.
REQ-011 char0..char5  out  2 each  display codes, char0 leftmost (feeds HEX5 decoder), char5 rightmost (HEX0).
REQ-012 loading  out  1  high in LOAD state.
REQ-013 tick  out  1  one-cycle scroll-step pulse.

Function
REQ-014 Two-state FSM: LOAD, RUN; wr_ready = loading = (state==LOAD), combinational.
REQ-015 Message store: MSG_LEN entries of 2 bits; BLANK code = 2'b11.
REQ-016 LOAD: each accepted write stores wr_data at wr_ptr, wr_ptr increments; write at wr_ptr==MSG_LEN-1 moves FSM to RUN next cycle, wr_ptr wraps to 0.
REQ-017 RUN: writes ignored (wr_ready=0); message contents frozen.
REQ-018 charI = msg[(offset+I) mod MSG_LEN], combinational from registered msg/offset, for I=0..5, in both states.
REQ-019 Prescaler counts 0..TICK_DIV-1 only when state==RUN and enable=1; holds value when enable=0; held at 0 in LOAD.
REQ-020 tick = 1 for exactly the cycle prescaler==TICK_DIV-1 while counting; prescaler wraps to 0 that cycle.
REQ-021 On tick: offset = (offset+1) mod MSG_LEN if dir=0, (offset-1) mod MSG_LEN if dir=1; wrap MSG_LEN-1<->0 without glitch.
REQ-022 dir sampled only on the tick cycle; changes between ticks have no other effect.
REQ-023 clear (any state): next cycle state=LOAD, all entries BLANK, wr_ptr=0, offset=0, prescaler=0; no tick that cycle.
REQ-024 clear wins over simultaneous write (write dropped) and over simultaneous tick (no offset advance).
REQ-025 Offset resets to 0 on LOAD->RUN transition so display starts at entry 0.

Reset
REQ-026 aclr low: state=LOAD, all msg entries BLANK, wr_ptr=0, offset=0, prescaler=0, tick=0; hence char0..5=2'b11, wr_ready=1, loading=1.
REQ-027 aclr asserted mid-load or mid-scroll discards all content immediately; deassertion resumes in LOAD.

Structure
REQ-028 Shared package scroll_pkg: state encodings LOAD/RUN, BLANK=2'b11, TICK_DIV default, ceiling-log2 function for pointer/prescaler widths.
REQ-029 One sub-module tick_prescaler (mod-TICK_DIV counter with enable, sync restart, tick output); remainder in msg_scroller.

Verification (TICK_DIV=4, MSG_LEN=8 in bench)
REQ-030 Reset: aclr low then high -> char0..5=11, wr_ready=1, loading=1, tick never asserts.
REQ-031 Load 00,01,10,11,00,01,10,00 with wr_valid held -> 8 accepts, wr_ready=0 after 8th, chars=00,01,10,11,00,01.
REQ-032 enable=1,dir=0 -> tick every 4th cycle; after 1 tick char0=01; after 8 ticks chars return to 00,01,10,11,00,01.
REQ-033 dir=1 from offset 0 -> after 1 tick char0=00 (msg[7]), char1=00, char2=01.
REQ-034 enable=0 at prescaler=2 for 10 cycles -> no tick; after re-enable tick after exactly 1 further cycle.
REQ-035 clear coincident with tick and wr_valid -> next cycle loading=1, all chars 11, offset 0, no advance; aclr pulse mid-RUN gives same result.
